// File: rtl/data_cache_controller_pkg.sv
// Shared definitions for the L1 data cache: FSM encodings, address field positions, byte merge.
// Optional hit/miss statistics are enabled by defining DCACHE_STATS_EN (see the top module).
package data_cache_controller_pkg;

    localparam logic [1:0] DC_IDLE      = 2'd0;
    localparam logic [1:0] DC_WRITEBACK = 2'd1;
    localparam logic [1:0] DC_ALLOCATE  = 2'd2;
    localparam logic [1:0] DC_UPDATE    = 2'd3;

    localparam int WORD_LSB  = 2;
    localparam int INDEX_LSB = 4;
    localparam int WORD_W    = 32;
    localparam int LINE_W    = 128;

    typedef struct packed {
        logic valid;
        logic dirty;
    } line_status_t;

    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [3:0]        byte_en
    );
        logic [WORD_W-1:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{byte_en[b]}};
        return (old_word & ~mask) | (new_word & mask);
    endfunction

endpackage

// File: rtl/data_cache_controller_storage.sv
// Line storage for the data cache: valid/dirty bits (reset), tag and data arrays (not reset).
// Byte-enabled word write and full-line refill are synchronous; reads are combinational.
module data_cache_controller_storage
    import data_cache_controller_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int TAG_W = 25,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  index,
    input  logic              word_we,
    input  logic [1:0]        word_sel,
    input  logic [3:0]        byte_en,
    input  logic [WORD_W-1:0] word_data,
    input  logic              fill_we,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_data,
    output line_status_t      status,
    output logic [TAG_W-1:0]  line_tag,
    output logic [LINE_W-1:0] line_data
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    // Tag and data survive reset; valid alone decides whether they mean anything.
    always_ff @(posedge clock) begin
        if (fill_we) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_data;
        end else if (word_we) begin
            data_q[index][{word_sel, 5'b0} +: WORD_W] <=
                merge_bytes(data_q[index][{word_sel, 5'b0} +: WORD_W], word_data, byte_en);
        end
    end

    assign status.valid = valid_q[index];
    assign status.dirty = dirty_q[index];
    assign line_tag     = tag_q[index];
    assign line_data    = data_q[index];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped write-back/write-allocate L1 data cache controller (FSM, hit logic, memory handshake).
// Define DCACHE_STATS_EN to add hit_count/miss_count outputs.
module data_cache_controller
    import data_cache_controller_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int TAG_W = 25
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         cpu_read,
    input  logic         cpu_write,
    input  logic [31:0]  cpu_address,
    input  logic [31:0]  cpu_write_data,
    input  logic [3:0]   cpu_byte_en,
    output logic [31:0]  cpu_read_data,
    output logic         cpu_busywait,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_address,
    output logic [127:0] mem_write_data,
    input  logic [127:0] mem_read_data,
    input  logic         mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);

    logic [1:0]        state_q, state_next;
    logic              entry_q;
    logic [TAG_W-1:0]  addr_tag;
    logic [IDX_W-1:0]  addr_idx;
    logic [1:0]        word_sel;
    line_status_t      status;
    logic [TAG_W-1:0]  line_tag;
    logic [LINE_W-1:0] line_data;
    logic              cpu_req, hit, fill_we, word_we;
    logic              addr_unused;

    assign addr_tag    = cpu_address[31 -: TAG_W];
    assign addr_idx    = cpu_address[INDEX_LSB +: IDX_W];
    assign word_sel    = cpu_address[WORD_LSB +: 2];
    assign addr_unused = ^cpu_address[1:0];

    assign cpu_req       = cpu_read | cpu_write;
    assign hit           = status.valid && (line_tag == addr_tag);
    assign cpu_read_data = line_data[{word_sel, 5'b0} +: WORD_W];
    // Read+write together is a store; a store after a miss commits in the IDLE cycle after UPDATE.
    assign word_we       = (state_q == DC_IDLE) && cpu_write && hit && !reset;

    data_cache_controller_storage #(
        .SETS  (SETS),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_storage (
        .clock     (clock),
        .reset     (reset),
        .index     (addr_idx),
        .word_we   (word_we),
        .word_sel  (word_sel),
        .byte_en   (cpu_byte_en),
        .word_data (cpu_write_data),
        .fill_we   (fill_we),
        .fill_tag  (addr_tag),
        .fill_data (mem_read_data),
        .status    (status),
        .line_tag  (line_tag),
        .line_data (line_data)
    );

    // mem_busywait is ignored in a state's entry cycle: memory may raise it combinationally.
    always_comb begin
        state_next     = state_q;
        cpu_busywait   = 1'b0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;
        fill_we        = 1'b0;
        case (state_q)
            DC_IDLE: begin
                if (cpu_req && !hit) begin
                    cpu_busywait = 1'b1;
                    state_next   = (status.valid && status.dirty) ? DC_WRITEBACK : DC_ALLOCATE;
                end
            end
            DC_WRITEBACK: begin
                cpu_busywait   = 1'b1;
                mem_write      = 1'b1;
                mem_address    = {line_tag, addr_idx};
                mem_write_data = line_data;
                if (!entry_q && !mem_busywait) state_next = DC_ALLOCATE;
            end
            DC_ALLOCATE: begin
                cpu_busywait = 1'b1;
                mem_read     = 1'b1;
                mem_address  = cpu_address[31:4];
                if (!entry_q && !mem_busywait) begin
                    fill_we    = 1'b1;
                    state_next = DC_UPDATE;
                end
            end
            DC_UPDATE: begin
                cpu_busywait = 1'b1;
                state_next   = DC_IDLE;
            end
        endcase
        if (reset) begin
            cpu_busywait   = 1'b0;
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            mem_address    = '0;
            mem_write_data = '0;
            fill_we        = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DC_IDLE;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_next;
            entry_q <= (state_next != state_q);
        end
    end

`ifdef DCACHE_STATS_EN
    // Marks that the request now in IDLE already counted as a miss.
    logic miss_pending;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count    <= '0;
            miss_count   <= '0;
            miss_pending <= 1'b0;
        end else if (state_q == DC_IDLE) begin
            miss_pending <= cpu_req && !hit;
            if (cpu_req && !hit)
                miss_count <= miss_count + 32'd1;
            else if (cpu_req && !miss_pending)
                hit_count <= hit_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache_controller.sv
// Randomized self-checking bench: flat byte-memory reference plus a tag/dirty residency model.
module tb_data_cache_controller;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         cpu_read = 1'b0, cpu_write = 1'b0;
    logic [31:0]  cpu_address = '0, cpu_write_data = '0;
    logic [3:0]   cpu_byte_en = '0;
    logic [31:0]  cpu_read_data;
    logic         cpu_busywait, mem_read, mem_write, mem_busywait;
    logic [27:0]  mem_address;
    logic [127:0] mem_write_data, mem_read_data;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    always #5 clock = ~clock;

    data_cache_controller #(.SETS(8), .TAG_W(25)) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .cpu_byte_en    (cpu_byte_en),
        .cpu_read_data  (cpu_read_data),
        .cpu_busywait   (cpu_busywait),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data),
        .mem_busywait   (mem_busywait)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count      (hit_count),
        .miss_count     (miss_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CPU-visible reference memory (bytes) and backing store (blocks), addresses below 1 KiB.
    logic [7:0]   ref_mem [1024];
    logic [127:0] back    [64];
    bit           mv [8];
    bit           md [8];
    int           mt [8];
    int           exp_hits = 0, exp_miss = 0;

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int a;
        a = int'(addr[9:2]) * 4;
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    function automatic logic [127:0] ref_block(input int b);
        logic [127:0] blk;
        for (int k = 0; k < 16; k++) blk[8*k +: 8] = ref_mem[b*16 + k];
        return blk;
    endfunction

    // Memory: busywait for `lat` cycles from the start of each request, then one completion edge.
    int           mcnt = 0;
    int           wlat = 1, alat = 1;
    int           wb_cnt = 0, al_cnt = 0;
    logic [27:0]  exp_wb_addr = '0, exp_al_addr = '0;
    logic [127:0] exp_wb_data = '0;

    assign mem_busywait  = mem_write ? (mcnt < wlat) : mem_read ? (mcnt < alat) : 1'b0;
    assign mem_read_data = back[mem_address[5:0]];

    always @(posedge clock) begin
        if ((mem_read || mem_write) && mem_busywait) mcnt <= mcnt + 1;
        else mcnt <= 0;
    end

    always @(negedge clock) begin
        chk("rw_exclusive", {1'b0, mem_read && mem_write}, 2'b00);
        if (mem_write && !mem_busywait) begin
            chk("wb_addr", mem_address, exp_wb_addr);
            chk("wb_data", mem_write_data, exp_wb_data);
            back[mem_address[5:0]] = mem_write_data;
            wb_cnt++;
        end
        if (mem_read && !mem_busywait) begin
            chk("alloc_addr", mem_address, exp_al_addr);
            al_cnt++;
        end
    end

    task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata);
        int idx, tag, exp_st, st, wb0, al0;
        bit hit, evict;
        idx   = int'(addr[6:4]);
        tag   = int'(addr[31:7]);
        hit   = mv[idx] && (mt[idx] == tag);
        evict = !hit && mv[idx] && md[idx];
        wlat  = $urandom_range(1, 3);
        alat  = $urandom_range(1, 3);
        if (evict) begin
            exp_wb_addr = 28'(mt[idx] * 8 + idx);
            exp_wb_data = ref_block(mt[idx] * 8 + idx);
        end
        exp_al_addr = addr[31:4];
        exp_st = hit ? 0 : (alat + 3 + (evict ? wlat + 1 : 0));
        wb0 = wb_cnt;
        al0 = al_cnt;
        @(negedge clock);
        cpu_read = rd; cpu_write = wr; cpu_address = addr;
        cpu_write_data = wdata; cpu_byte_en = be;
        #1;
        st = 0;
        while (cpu_busywait && st < 100) begin
            @(negedge clock);
            #1;
            st++;
        end
        rdata = cpu_read_data;
        chk("stall_cycles", st, exp_st);
        if (!wr) chk("load_data", rdata, ref_word(addr));
        @(posedge clock);
        #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
        chk("wb_events", wb_cnt - wb0, evict ? 1 : 0);
        chk("alloc_events", al_cnt - al0, hit ? 0 : 1);
        if (!hit) begin
            mv[idx] = 1'b1; mt[idx] = tag; md[idx] = 1'b0;
            exp_miss++;
        end else begin
            exp_hits++;
        end
        if (wr) begin
            md[idx] = 1'b1;
            for (int b = 0; b < 4; b++)
                if (be[b]) ref_mem[int'(addr[9:2]) * 4 + b] = wdata[8*b +: 8];
        end
    endtask

    initial begin
        logic [31:0] rd;
        int n;
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i * 37 + 11);
        for (int b = 0; b < 64; b++) back[b] = ref_block(b);
        for (int s = 0; s < 8; s++) begin mv[s] = 0; md[s] = 0; mt[s] = 0; end

        // A pending request during reset must not stall or reach memory.
        cpu_read = 1'b1; cpu_address = 32'h40;
        repeat (2) @(negedge clock);
        #1;
        chk("rst_busywait", cpu_busywait, 1'b0);
        chk("rst_mem_read", mem_read, 1'b0);
        chk("rst_mem_write", mem_write, 1'b0);
        chk("rst_mem_address", mem_address, 28'h0);
        chk("rst_mem_wdata", mem_write_data, 128'h0);
        @(negedge clock);
        reset = 1'b0; cpu_read = 1'b0;

        // Directed sequence from block 4 through a dirty conflict.
        {ref_mem[67], ref_mem[66], ref_mem[65], ref_mem[64]} = 32'hDEADBEEF;
        back[4][31:0] = 32'hDEADBEEF;
        access(1, 0, 32'h40, '0, '0, rd);
        chk("refill_word0", rd, 32'hDEADBEEF);
        access(1, 0, 32'h40, '0, '0, rd);
        access(0, 1, 32'h40, 32'h12345678, 4'b1111, rd);
        access(1, 0, 32'h40, '0, '0, rd);
        chk("sw_readback", rd, 32'h12345678);
        access(0, 1, 32'h41, 32'h0000AB00, 4'b0010, rd);
        access(1, 0, 32'h40, '0, '0, rd);
        chk("sb_merge", rd, 32'h1234AB78);
        access(1, 0, 32'hC0, '0, '0, rd);
        chk("conflict_back", back[4][31:0], 32'h1234AB78);

        // Reset while ALLOCATE is waiting on memory.
        alat = 50;
        @(negedge clock);
        cpu_read = 1'b1; cpu_address = 32'h40;
        n = 0;
        while (!mem_read && n < 20) begin @(negedge clock); n++; end
        chk("alloc_reached", mem_read, 1'b1);
        reset = 1'b1; cpu_read = 1'b0;
        @(posedge clock);
        #1;
        chk("abort_mem_read", mem_read, 1'b0);
        chk("abort_busywait", cpu_busywait, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        for (int s = 0; s < 8; s++) begin mv[s] = 0; md[s] = 0; end
        exp_hits = 0; exp_miss = 0;
        access(1, 0, 32'h40, '0, '0, rd);

        // Random mix over 4 tags x 8 sets to force conflicts and dirty evictions.
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            bit wr, rdq;
            a   = {22'h0, 3'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   2'($urandom_range(0, 3)), 2'b00};
            wr  = $urandom_range(0, 1) == 1;
            rdq = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
            access(rdq, wr, a, $urandom, 4'($urandom_range(1, 15)), rd);
        end

`ifdef DCACHE_STATS_EN
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_miss);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
